tick_stopwatch: RTL and testbench
=================================

// Module: tick_stopwatch
// PURPOSE
//  Downstream consumer of the divided slow clock (clk_out of the clock divider, ~1 Hz).
//  Synchronises that slow clock into the system clock domain and detects its rising edges.
//  Runs a start/stop/clear BCD mm:ss stopwatch (00:00..59:59) driven by those edges.
//  Outputs four BCD digits to the seven-segment display stage; all logic is clocked by clk only.
// PARAMETERS
//  SYNC_STAGES  2  flops in the tick_clk synchroniser; minimum 2.
// PORTS
//  clk       in   1  system clock; every register is clocked on posedge clk
//  rst       in   1  asynchronous, active-low reset (rst==0 resets)
//  tick_clk  in   1  divided slow clock from clock divider; asynchronous to clk
//  start     in   1  start/resume request, sampled each clk
//  stop      in   1  pause request, sampled each clk
//  clear     in   1  zero digits and return to IDLE, sampled each clk
//  sec_ones  out  4  BCD seconds units, 0..9
//  sec_tens  out  4  BCD seconds tens, 0..5
//  min_ones  out  4  BCD minutes units, 0..9
//  min_tens  out  4  BCD minutes tens, 0..5
//  running   out  1  1 while FSM is in RUN
//  rollover  out  1  1-cycle pulse on 59:59 -> 00:00 wrap
// BEHAVIOUR
//  Reset (rst==0, async): digits=0, running=0, rollover=0, FSM=IDLE, sync chain and edge flop=0.
//  Sync: tick_clk -> SYNC_STAGES flops -> delay flop d; tick_pulse = last_sync & ~d.
//   - tick_pulse lasts exactly 1 clk per tick_clk rising edge, however long tick_clk stays high.
//   - Latency: tick_clk first sampled high at edge k -> digits update at edge k+SYNC_STAGES.
//   - Falling edges of tick_clk are ignored.
//  FSM states: IDLE (digits 00:00, stopped), RUN (counting), PAUSE (held, stopped).
//   - IDLE: start -> RUN.  RUN: stop -> PAUSE.  PAUSE: start -> RUN.
//   - clear in any state -> IDLE, digits -> 00:00 at that same edge.
//   - Priority when simultaneous: clear > stop > start; stop+start in RUN -> PAUSE.
//   - start in RUN, stop in IDLE/PAUSE: no effect.
//  Counting: increment only at edges where tick_pulse==1 and FSM is RUN before the edge.
//   - tick_pulse on the same edge as start from IDLE/PAUSE: not counted.
//   - tick_pulse on the same edge as stop in RUN: not counted (stop wins).
//   - tick_pulse with clear: clear wins, result 00:00.
//   - Carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones;
//     min_ones 9->0 carries to min_tens; min_tens 5->0 is the wrap.
//   - 59:59 + tick -> 00:00, rollover=1 for exactly the following cycle; FSM stays RUN.
//   - Digits never leave their legal BCD ranges; no binary-to-BCD conversion is used.
//  running is a registered output: 1 from the edge FSM enters RUN until the edge it leaves.
//  Reset mid-operation: immediate return to reset values, no partial carry is kept.
//   - After rst deasserts, a tick_clk already high may produce one tick_pulse.
//     FSM is IDLE at that point, so the pulse is not counted.
// TESTING
//  1 rst=0 then release, tick_clk toggling -> digits 00:00, running=0, rollover=0; no count.
//  2 start pulse, then 3 tick_clk rising edges -> 00:03; each update SYNC_STAGES clks after sampling.
//  3 tick_clk held high 1000 clks -> exactly one increment; run from 00:09 -> 00:10; 00:59 -> 01:00.
//  4 preload to 59:58 via ticks, then 2 ticks -> 59:59, then 00:00; rollover high 1 cycle; running=1.
//  5 at 00:05: stop, 4 ticks -> still 00:05, running=0; start, 1 tick -> 00:06.
//  6 clear on same edge as tick_pulse at 12:34 -> 00:00, IDLE; rst=0 mid-RUN -> 00:00 asynchronously.

Source files
------------

// File: rtl/tick_stopwatch_if.sv
// Signal bundle between the stopwatch and its driver: slow tick, control strobes,
// and the four BCD digits plus status flags going to the display stage.
interface tick_stopwatch_if;
  logic       tick_clk_i;
  logic       start_i;
  logic       stop_i;
  logic       clear_i;
  logic [3:0] sec_ones_o;
  logic [3:0] sec_tens_o;
  logic [3:0] min_ones_o;
  logic [3:0] min_tens_o;
  logic       running_o;
  logic       rollover_o;

  modport slave (
    input  tick_clk_i, start_i, stop_i, clear_i,
    output sec_ones_o, sec_tens_o, min_ones_o, min_tens_o, running_o, rollover_o
  );

  modport master (
    output tick_clk_i, start_i, stop_i, clear_i,
    input  sec_ones_o, sec_tens_o, min_ones_o, min_tens_o, running_o, rollover_o
  );
endinterface

// File: rtl/tick_stopwatch.sv
// BCD mm:ss stopwatch advanced by rising edges of an asynchronous ~1 Hz tick clock,
// with start/stop/clear control. Everything is clocked by clk.
module tick_stopwatch #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic              clk,
  input  logic              rst_n,
  tick_stopwatch_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick_pulse;
  logic                   count_en;
  logic [3:0]             sec_ones_q, sec_ones_d;
  logic [3:0]             sec_tens_q, sec_tens_d;
  logic [3:0]             min_ones_q, min_ones_d;
  logic [3:0]             min_tens_q, min_tens_d;
  logic                   running_q;
  logic                   rollover_q, rollover_d;

  assign tick_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

  // A tick coinciding with stop or clear is dropped: those controls take precedence.
  assign count_en = (state_q == RUN) && tick_pulse && !bus.clear_i && !bus.stop_i;

  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start_i) state_d = RUN;
        RUN:     if (bus.stop_i)  state_d = PAUSE;
        PAUSE:   if (bus.start_i) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    rollover_d = 1'b0;
    if (bus.clear_i) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (count_en) begin
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            if (min_tens_q != 4'd5) begin
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_tens_d = 4'd0;
              rollover_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      state_q    <= IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.tick_clk_i};
      edge_q     <= sync_q[SYNC_STAGES-1];
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= (state_d == RUN);
      rollover_q <= rollover_d;
    end
  end

  assign bus.sec_ones_o = sec_ones_q;
  assign bus.sec_tens_o = sec_tens_q;
  assign bus.min_ones_o = min_ones_q;
  assign bus.min_tens_o = min_tens_q;
  assign bus.running_o  = running_q;
  assign bus.rollover_o = rollover_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Scoreboard bench: a seconds-count reference model predicts every cycle's outputs,
// a monitor compares them, and directed steps check the key values explicitly.
module tb_tick_stopwatch;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  tick_stopwatch_if bus ();

  tick_stopwatch #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=run 2=pause, elapsed seconds as a plain integer.
  logic [17:0] exp_q[$];
  int          m_mode;
  int          m_secs;
  bit          m_hist[$];

  function automatic logic [17:0] pack_exp(int secs, bit run, bit roll);
    int mins;
    int sec;
    mins = secs / 60;
    sec  = secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(sec / 10), 4'(sec % 10), run, roll};
  endfunction

  task automatic reset_model();
    m_mode = 0;
    m_secs = 0;
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back(1'b0);
  endtask

  initial reset_model();

  always @(posedge clk) begin : model
    bit pulse;
    bit roll;
    roll = 1'b0;
    if (!rst_n) begin
      reset_model();
    end else begin
      // tick seen high S edges ago but low the edge before that => one count opportunity
      pulse = m_hist[S-1] && !m_hist[S];
      m_hist.push_front(bus.tick_clk_i);
      void'(m_hist.pop_back());
      if (bus.clear_i) begin
        m_mode = 0;
        m_secs = 0;
      end else if (m_mode == 1) begin
        if (bus.stop_i) m_mode = 2;
        else if (pulse) begin
          m_secs = (m_secs + 1) % 3600;
          roll = (m_secs == 0);
        end
      end else if (bus.start_i) begin
        m_mode = 1;
      end
    end
    exp_q.push_back(pack_exp(m_secs, m_mode == 1, roll));
  end

  function automatic logic [17:0] dut_vec();
    return {bus.min_tens_o, bus.min_ones_o, bus.sec_tens_o, bus.sec_ones_o,
            bus.running_o, bus.rollover_o};
  endfunction

  always @(posedge clk) begin : monitor
    logic [17:0] e;
    logic [17:0] g;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      g = dut_vec();
      if (g !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got mm:ss=%h run=%b roll=%b expected mm:ss=%h run=%b roll=%b",
                 $time, g[17:2], g[1], g[0], e[17:2], e[1], e[0]);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.min_tens_o, bus.min_ones_o, bus.sec_tens_o, bus.sec_ones_o};
  endfunction

  task automatic tick(int hi, int lo);
    @(negedge clk) bus.tick_clk_i = 1'b1;
    repeat (hi) @(negedge clk);
    bus.tick_clk_i = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick($urandom_range(1, 3), $urandom_range(2, 3));
  endtask

  task automatic do_start();
    @(negedge clk) bus.start_i = 1'b1;
    @(negedge clk) bus.start_i = 1'b0;
    $display("TXN start  t=%0t mm:ss=%h", $time, digits());
  endtask

  task automatic do_stop();
    @(negedge clk) bus.stop_i = 1'b1;
    @(negedge clk) bus.stop_i = 1'b0;
    $display("TXN stop   t=%0t mm:ss=%h", $time, digits());
  endtask

  task automatic do_clear();
    @(negedge clk) bus.clear_i = 1'b1;
    @(negedge clk) bus.clear_i = 1'b0;
    $display("TXN clear  t=%0t mm:ss=%h", $time, digits());
  endtask

  // Raise tick and assert one control on exactly the edge where its pulse lands.
  task automatic tick_with(int which);
    @(negedge clk) bus.tick_clk_i = 1'b1;
    repeat (S) @(negedge clk);
    case (which)
      0: bus.start_i = 1'b1;
      1: bus.stop_i  = 1'b1;
      default: bus.clear_i = 1'b1;
    endcase
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.clear_i = 1'b0;
    bus.tick_clk_i = 1'b0;
    repeat (3) @(negedge clk);
    $display("TXN tick+ctl%0d t=%0t mm:ss=%h", which, $time, digits());
  endtask

  initial begin
    bus.tick_clk_i = 1'b0;
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    bus.clear_i = 1'b0;

    // reset with tick toggling, then idle ticks must not count
    tick(1, 1); tick(2, 1);
    @(negedge clk) rst_n = 1'b1;
    ticks(3);
    chk("idle_digits", 32'(digits()), 32'h0000);
    chk("idle_running", 32'(bus.running_o), 32'h0);
    chk("idle_rollover", 32'(bus.rollover_o), 32'h0);

    do_start();
    chk("start_running", 32'(bus.running_o), 32'h1);
    ticks(3);
    chk("three_ticks", 32'(digits()), 32'h0003);

    // long high tick counts once; BCD carries
    ticks(6);
    chk("at_0009", 32'(digits()), 32'h0009);
    @(negedge clk) bus.tick_clk_i = 1'b1;
    repeat (1000) @(negedge clk);
    chk("held_high_once", 32'(digits()), 32'h0010);
    bus.tick_clk_i = 1'b0;
    repeat (3) @(negedge clk);
    ticks(49);
    chk("at_0059", 32'(digits()), 32'h0059);
    ticks(1);
    chk("carry_0100", 32'(digits()), 32'h0100);

    // wrap 59:59 -> 00:00
    do_clear();
    do_start();
    ticks(3598);
    chk("at_5958", 32'(digits()), 32'h5958);
    ticks(1);
    chk("at_5959", 32'(digits()), 32'h5959);
    @(negedge clk) bus.tick_clk_i = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    chk("wrap_digits", 32'(digits()), 32'h0000);
    chk("wrap_rollover", 32'(bus.rollover_o), 32'h1);
    chk("wrap_running", 32'(bus.running_o), 32'h1);
    @(posedge clk);
    #1;
    chk("rollover_one_cycle", 32'(bus.rollover_o), 32'h0);
    @(negedge clk) bus.tick_clk_i = 1'b0;
    repeat (3) @(negedge clk);

    // pause behaviour and same-edge precedence
    do_clear();
    do_start();
    ticks(5);
    chk("at_0005", 32'(digits()), 32'h0005);
    do_stop();
    chk("stop_running", 32'(bus.running_o), 32'h0);
    ticks(4);
    chk("paused_hold", 32'(digits()), 32'h0005);
    do_start();
    ticks(1);
    chk("resume_0006", 32'(digits()), 32'h0006);
    tick_with(1);
    chk("stop_beats_tick", 32'(digits()), 32'h0006);
    tick_with(0);
    chk("start_tick_uncounted", 32'(digits()), 32'h0006);
    chk("start_tick_running", 32'(bus.running_o), 32'h1);
    ticks(1);
    chk("after_resume_0007", 32'(digits()), 32'h0007);

    // clear vs tick, async reset mid-run, tick high across reset release
    do_clear();
    do_start();
    ticks(754);
    chk("at_1234", 32'(digits()), 32'h1234);
    tick_with(2);
    chk("clear_beats_tick", 32'(digits()), 32'h0000);
    chk("clear_idle", 32'(bus.running_o), 32'h0);
    do_start();
    ticks(3);
    @(negedge clk) #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits()), 32'h0000);
    chk("async_rst_running", 32'(bus.running_o), 32'h0);
    bus.tick_clk_i = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_start();
    repeat (5) @(negedge clk);
    chk("post_rst_pulse_ignored", 32'(digits()), 32'h0000);
    bus.tick_clk_i = 1'b0;
    repeat (3) @(negedge clk);
    do_clear();

    // randomized traffic, checked only by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bus.tick_clk_i = ~bus.tick_clk_i;
      bus.start_i = ($urandom_range(0, 7) == 0);
      bus.stop_i  = ($urandom_range(0, 15) == 0);
      bus.clear_i = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    bus.clear_i = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
